// File: rtl/avalon_ram_pkg.sv
// Shared types and helpers for the Avalon-MM wait-state RAM.
package avalon_ram_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Galois toggle mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int unsigned WORD_BYTES = 4;

    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned words);
        logic [31:0] off;
        off = addr - base;
        return off < (words * WORD_BYTES);
    endfunction

    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

endpackage

// File: rtl/ram_wait_lfsr.sv
// 16-bit Galois LFSR that advances one step per asserted step cycle.
module ram_wait_lfsr
    import avalon_ram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with wait-state generator, byte lanes and preload port.
// Define RAM_RANDOM_WAIT_EN for LFSR-driven per-transfer wait counts.
module avalon_wait_ram
    import avalon_ram_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    address,
    input  logic                           read,
    input  logic                           write,
    output logic                           waitrequest,
    input  logic [31:0]                    writedata,
    input  logic [3:0]                     byteenable,
    output logic [31:0]                    readdata,
    input  logic                           preload_en,
    input  logic [$clog2(MEM_WORDS)+1:0]   preload_addr,
    input  logic [31:0]                    preload_data,
    output logic                           protocol_err
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic          rd_q;
    logic          wr_q;
    logic          err_q;

    logic          request;
    logic          violation;
    logic          at_n;
    logic          start;
    logic          complete;
    logic          in_win;
    logic          bus_wr;
    logic [3:0]    n_cur;
    logic [31:0]   off_word;
    logic [AW-1:0] idx;
    logic [AW-1:0] pidx;

    logic [31:0]   mem [MEM_WORDS];

    assign request   = read | write;
    assign violation = (state_q == BUSY) &&
                       ((address != addr_q) || (read != rd_q) || (write != wr_q));
    assign at_n      = (cnt_q == n_cur);
    assign start     = (state_q == IDLE) && request && !at_n;
    assign complete  = !reset && request && at_n && !violation;

    assign in_win    = addr_in_window(address, BASE_ADDR, MEM_WORDS);
    assign off_word  = word_offset(address, BASE_ADDR);
    assign idx       = off_word[AW-1:0];
    assign pidx      = preload_addr[AW+1:2];
    assign bus_wr    = complete && write && in_win;

    // Outputs are forced to their idle values while reset is held.
    assign waitrequest  = !reset && request && !at_n;
    assign readdata     = (complete && read && !write && in_win) ? mem[idx] : '0;
    assign protocol_err = err_q;

`ifdef RAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_state;
    logic [3:0]  n_rand;
    logic [3:0]  n_q;

    ram_wait_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  ((state_q == IDLE) && request),
        .state (lfsr_state)
    );

    assign n_rand = 4'({1'b0, lfsr_state[3:0]} % 5'(WAIT_CYCLES + 1));
    // The wait count is drawn once in IDLE and then held for the whole transfer.
    assign n_cur  = (state_q == BUSY) ? n_q : n_rand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= '0;
        end else if (start) begin
            n_q <= n_rand;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{off_word[31:AW], preload_addr[1:0], lfsr_state[15:4]};
`else
    assign n_cur = 4'(WAIT_CYCLES);

    logic unused_bits;
    assign unused_bits = ^{off_word[31:AW], preload_addr[1:0]};
`endif

    // Transfer control FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (violation || (read && write)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_q    <= read;
                        wr_q    <= write;
                        cnt_q   <= 4'd1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (violation || at_n) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            addr_q <= address;
        end
    end

    // Storage: a completing bus write to the same word overrides the preload.
    always_ff @(posedge clk) begin
        if (preload_en && !(bus_wr && (pidx == idx))) begin
            mem[pidx] <= preload_data;
        end
        if (bus_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Scoreboard bench for avalon_wait_ram: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_avalon_wait_ram;

    localparam logic [31:0] BASE = 32'hBFC00000;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writedata, readdata, preload_data;
    logic        read, write, waitrequest, preload_en, protocol_err;
    logic [3:0]  byteenable;
    logic [9:0]  preload_addr;

    logic [31:0] a0, wd0, rdd0, pd0;
    logic        rd0, wr0, wrq0, pe0, err0;
    logic [3:0]  be0;
    logic [9:0]  pa0;

    always #5 clk = ~clk;

    avalon_wait_ram #(.MEM_WORDS(256), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .preload_en(preload_en), .preload_addr(preload_addr),
        .preload_data(preload_data), .protocol_err(protocol_err)
    );

    avalon_wait_ram #(.MEM_WORDS(256), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst), .address(a0), .read(rd0), .write(wr0),
        .waitrequest(wrq0), .writedata(wd0), .byteenable(be0),
        .readdata(rdd0), .preload_en(pe0), .preload_addr(pa0),
        .preload_data(pd0), .protocol_err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Monitor for the WAIT_CYCLES=2 instance
    initial begin
        int   stall2;
        exp_t e;
        stall2 = 0;
        forever begin
            @(negedge clk);
            if (rst || !(read || write)) begin
                stall2 = 0;
            end else if (waitrequest) begin
                stall2++;
            end else begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion addr=%08h", address);
                end else begin
                    e = q2.pop_front();
`ifdef RAM_RANDOM_WAIT_EN
                    checks++;
                    if (stall2 > 2) begin
                        errors++;
                        $display("FAIL waits actual=%0d limit=2", stall2);
                    end
`else
                    check("waits", 32'(stall2), 32'(e.waits));
`endif
                    if (e.chk) check("readdata", readdata, e.data);
                end
                stall2 = 0;
            end
        end
    end

    // Monitor for the WAIT_CYCLES=0 instance
    initial begin
        int   stall0;
        exp_t e;
        stall0 = 0;
        forever begin
            @(negedge clk);
            if (rst || !(rd0 || wr0)) begin
                stall0 = 0;
            end else if (wrq0) begin
                stall0++;
            end else begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion0 addr=%08h", a0);
                end else begin
                    e = q0.pop_front();
                    check("waits0", 32'(stall0), 32'(e.waits));
                    if (e.chk) check("readdata0", rdd0, e.data);
                end
                stall0 = 0;
            end
        end
    end

    task automatic preload(input logic [9:0] off, input logic [31:0] d);
        preload_en   = 1'b1;
        preload_addr = off;
        preload_data = d;
        @(posedge clk); #1;
        preload_en   = 1'b0;
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic chk, input logic [31:0] exp, input int waits);
        int n;
        q2.push_back('{chk, exp, waits});
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (waitrequest && n < 40);
        if (waitrequest) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%08h waited=%0d", a, n);
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic rd2(input logic [31:0] a, input logic [31:0] exp);
        xfer(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, exp, 2);
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        xfer(1'b0, 1'b1, a, d, be, 1'b0, 32'h0, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
        preload_en = 1'b0; preload_addr = '0; preload_data = '0;
        a0 = '0; rd0 = 1'b0; wr0 = 1'b0; wd0 = '0; be0 = '0;
        pe0 = 1'b0; pa0 = '0; pd0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);
        check("rst_cnt", 32'(dut.cnt_q), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        preload(10'h000, 32'h01020304);
        preload(10'h004, 32'h240ABFC0);
        preload(10'h008, 32'h08080808);
        preload(10'h00C, 32'h0C0C0C0C);
        preload(10'h010, 32'h11223344);
        preload(10'h014, 32'h14141414);
        preload(10'h018, 32'h18181818);
        preload(10'h020, 32'hCAFEF00D);
        preload(10'h040, 32'h5A5A5A5A);
        preload(10'h3FC, 32'h13579BDF);

        rd2(BASE + 32'h04, 32'h240ABFC0);
        wr2(BASE + 32'h10, 32'hAABBCCDD, 4'b0101);
        rd2(BASE + 32'h10, 32'h11BB33DD);
        rd2(BASE + 32'h07, 32'h240ABFC0);
        wr2(BASE + 32'h04, 32'hFFFFFFFF, 4'b0000);
        rd2(BASE + 32'h04, 32'h240ABFC0);

        // Out of window: handshake normal, no data, no write
        rd2(32'h00000040, 32'h0);
        wr2(32'h00000040, 32'hFFFFFFFF, 4'b1111);
        rd2(BASE + 32'h40, 32'h5A5A5A5A);
        rd2(BASE + 32'h00, 32'h01020304);
        rd2(BASE + 32'h3FC, 32'h13579BDF);
        rd2(BASE + 32'h400, 32'h0);

        // Preload and bus write to the same word at the completing edge
        preload_en = 1'b1; preload_addr = 10'h008; preload_data = 32'h77777777;
        wr2(BASE + 32'h08, 32'h0BADBEEF, 4'b1111);
        preload_en = 1'b0;
        rd2(BASE + 32'h08, 32'h0BADBEEF);

        // Address change while stalled
        check("err_before", 32'(protocol_err), 32'd0);
        address = BASE + 32'h14; write = 1'b1; writedata = 32'hDEAD0000; byteenable = 4'hF;
        @(posedge clk); #1;
        address = BASE + 32'h18;
        @(posedge clk); #1;
        write = 1'b0;
        @(negedge clk);
        check("err_after_abort", 32'(protocol_err), 32'd1);
        check("state_after_abort", 32'(dut.state_q), 32'(avalon_ram_pkg::IDLE));
        check("wait_after_abort", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        rd2(BASE + 32'h14, 32'h14141414);
        rd2(BASE + 32'h18, 32'h18181818);

        // Reset during a pending write
        address = BASE + 32'h20; write = 1'b1; writedata = 32'h0; byteenable = 4'hF;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_wait", 32'(waitrequest), 32'd0);
        check("rst_mid_cnt", 32'(dut.cnt_q), 32'd0);
        check("rst_mid_state", 32'(dut.state_q), 32'(avalon_ram_pkg::IDLE));
        write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("err_cleared", 32'(protocol_err), 32'd0);
        rd2(BASE + 32'h20, 32'hCAFEF00D);

        // Simultaneous read and write
        xfer(1'b1, 1'b1, BASE + 32'h0C, 32'h12345678, 4'hF, 1'b1, 32'h0, 2);
        check("err_rdwr", 32'(protocol_err), 32'd1);
        rd2(BASE + 32'h0C, 32'h12345678);

        // Zero-wait instance: one transfer per cycle
        pe0 = 1'b1; pa0 = 10'h000; pd0 = 32'hA0000000;
        @(posedge clk); #1;
        pa0 = 10'h004; pd0 = 32'hA1111111;
        @(posedge clk); #1;
        pa0 = 10'h008; pd0 = 32'hA2222222;
        @(posedge clk); #1;
        pe0 = 1'b0;
        q0.push_back('{1'b1, 32'hA0000000, 0});
        q0.push_back('{1'b1, 32'hA1111111, 0});
        q0.push_back('{1'b1, 32'hA2222222, 0});
        rd0 = 1'b1; a0 = BASE;
        @(posedge clk); #1;
        a0 = BASE + 32'h04;
        @(posedge clk); #1;
        a0 = BASE + 32'h08;
        @(posedge clk); #1;
        rd0 = 1'b0;
        q0.push_back('{1'b0, 32'h0, 0});
        wr0 = 1'b1; wd0 = 32'h55000000; be0 = 4'b1000;
        @(posedge clk); #1;
        wr0 = 1'b0;
        q0.push_back('{1'b1, 32'h55222222, 0});
        rd0 = 1'b1;
        @(posedge clk); #1;
        rd0 = 1'b0;

`ifdef RAM_RANDOM_WAIT_EN
        for (int i = 0; i < 100; i++) begin
            rd2(BASE + 32'h04, 32'h240ABFC0);
        end
`endif

        repeat (3) @(posedge clk);
        check("q2_drained", 32'(q2.size()), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
- Avalon-MM slave memory: the responder to top_level_cpu's bus master (address/read/write/waitrequest/writedata/byteenable/readdata).
- Word-organised RAM with a programmable wait-state generator and byte-lane writes.
- Synchronous preload port so benches can load programs before releasing the CPU.
- Replaces ad-hoc bench RAMs and exercises the CPU's stall path.

Parameters:
- MEM_WORDS, 256, depth in 32-bit words (power of two).
- BASE_ADDR, 32'hBFC00000, byte address of word 0. Window is BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1.
- WAIT_CYCLES, 2, fixed wait states per transfer (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  32  byte address from master.
- read  in  1  read request.
- write  in  1  write request.
- waitrequest  out  1  stall; transfer completes in the cycle it is low.
- writedata  in  32  write data.
- byteenable  in  4  lane enables; bit i covers writedata[8i+7:8i].
- readdata  out  32  read data; valid when read=1 and waitrequest=0.
- preload_en  in  1  preload write strobe.
- preload_addr  in  $clog2(MEM_WORDS)+2  byte offset into the window; bits [1:0] ignored.
- preload_data  in  32  preload word.
- protocol_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: waitrequest=0, readdata=0, protocol_err=0, FSM=IDLE, wait counter=0.
- Memory contents are not cleared by reset.
- FSM states:
  - IDLE: no transfer in progress.
  - BUSY: counting wait states; cnt is 4 bits.
  - Latched per transfer: addr_q, rd_q, wr_q.
- Request = read|write.
- waitrequest = request && (cnt != N), combinational. N = WAIT_CYCLES unless the optional feature is enabled.
- IDLE:
  - request && N==0: complete in the same cycle, stay IDLE.
  - request && N>0: latch address/read/write, cnt<=1, go to BUSY.
- BUSY:
  - cnt<N: cnt<=cnt+1.
  - cnt==N: waitrequest low; transfer completes at this edge; cnt<=0; go to IDLE.
- Transfer latency: the request is held N+1 cycles. Back-to-back requests each pay N again. With N=0, one transfer completes per cycle.
- Read:
  - readdata = mem[word] (combinational array read) while read && !waitrequest && in-window; otherwise 0.
- Write:
  - Commits at the completing edge.
  - Only lanes with byteenable set are updated.
  - byteenable=0 is a legal no-op.
- Out-of-window address: handshake proceeds normally; reads return 0; writes are dropped.
- Word index = (address-BASE_ADDR)>>2. address[1:0] is ignored.
- Protocol violations (each sets protocol_err, which stays set until reset):
  - In BUSY, address, read or write differs from the latched value: abort, no write, go to IDLE.
  - read && write both asserted: the write is performed and readdata=0.
- Preload:
  - preload_en writes the full word at the rising edge.
  - If a bus write completes to the same word in the same cycle, the bus write wins.
  - Preload does not affect the FSM.
- Reset mid-transfer: FSM returns to IDLE immediately; the pending write is discarded.

Optional Feature:
- Macro: RAM_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances one step per transfer start.
  - N = lfsr[3:0] mod (WAIT_CYCLES+1), sampled when leaving IDLE. N=0 still completes same-cycle.
- Undefined: N = WAIT_CYCLES always; no LFSR logic is synthesised.

Decomposition:
- Package avalon_ram_pkg holds:
  - state enum (IDLE, BUSY);
  - LFSR_SEED, LFSR_TAPS;
  - WORD_BYTES=4;
  - a function for the window check / word index.
- Sub-module ram_wait_lfsr: LFSR with step input and 16-bit state output. Instantiated only under RAM_RANDOM_WAIT_EN.

Test Plan:
- Preload BASE+0x04=32'h240ABFC0, then read 0xBFC00004 with WAIT_CYCLES=2 -> waitrequest high 2 cycles, low on 3rd, readdata=32'h240ABFC0.
- Write 0xBFC00010, data 32'hAABBCCDD, byteenable 4'b0101, over prior 32'h11223344 -> readback 32'h11BB33DD.
- WAIT_CYCLES=0, reads every cycle to 0xBFC00000/04/08 -> waitrequest never high, three words returned in three cycles.
- Read 0x00000040 (out of window) -> normal handshake, readdata=0; a write there leaves all RAM words unchanged.
- Master changes address while waitrequest high -> protocol_err=1, no memory change, FSM in IDLE the next cycle.
- Reset pulse during BUSY of a write to 0xBFC00020 -> word keeps its old value, waitrequest=0, cnt=0. With RAM_RANDOM_WAIT_EN: 100 reads each complete within WAIT_CYCLES+1 cycles and return correct data.
